host_reg_bridge: RTL
====================

# host_reg_bridge

Parametrised AHB-Lite slave bridge on `macPIClk`. It decodes host accesses into `NUM_TGT` register windows (CSR bank, MIB controller, and future targets) and issues one-cycle read/write strobes to the selected target. It stalls the bus until that target handshakes, then returns the read data. It replaces the fixed two-way reg/MIB split with an N-way decode, byte enables, error responses for illegal accesses, and an optional per-access timeout.

## Interface
Parameters:
- `NUM_TGT`, 4: number of target windows; power of two, 2..8.
- `TGT_ADDR_W`, 10: byte-address width inside one window.
- `ADDR_W`, 16: width of `hSAddr`; must be ≥ `TGT_ADDR_W` + log2(`NUM_TGT`).
- `DATA_W`, 32: data width; fixed at 32 for this generation.
- `TIMEOUT_CYC`, 255: wait-cycle limit before an error response; 1..65535.

Ports:
- `macPIClk`  in  1: the block's only clock.
- `macPIClkHardRst`  in  1: reset, synchronous and active-high.
- `hSSel`, `hSWrite`, `hSReadyIn`  in  1 each: AHB slave controls.
- `hSTrans`  in  2: AHB transfer type.
- `hSSize`  in  3: AHB transfer size.
- `hSAddr`  in  `ADDR_W`: AHB address.
- `hSWData`  in  32: AHB write data.
- `hSRData`  out  32: read data, registered.
- `hSReadyOut`  out  1: slave ready.
- `hSResp`  out  2: `00` OKAY, `01` ERROR.
- `tgtSel`  out  `NUM_TGT`: one-hot target select, held from strobe until completion.
- `tgtWrite`, `tgtRead`  out  1 each: one-cycle strobes.
- `tgtAddr`  out  `TGT_ADDR_W`: window-relative byte address.
- `tgtWData`  out  32: write data.
- `tgtBe`  out  4: byte enables.
- `tgtReady`  in  `NUM_TGT`: per-target completion.
- `tgtRData`  in  `NUM_TGT`*32: per-target read data; slice i belongs to target i.

## Operation
- Accept an address phase when `hSSel`, `hSTrans[1]` and `hSReadyIn` are all 1. IDLE and BUSY transfers get a zero-wait OKAY.
- Decode:
  - index = `hSAddr[TGT_ADDR_W +: log2(NUM_TGT)]`.
  - The access is unmapped if any `hSAddr` bit above the index field is 1.
  - The access is illegal if `hSSize` > 2, or if it is misaligned (halfword with `hSAddr[0]`=1, word with `hSAddr[1:0]`≠0).
- Byte enables: byte → `0001` << `addr[1:0]`; halfword → `0011` << {`addr[1]`,0}; word → `1111`.
- FSM states: IDLE, ACCESS, WAIT, DONE, ERR1, ERR2.
  - IDLE/DONE/ERR2 + accepted, legal access → ACCESS.
  - IDLE/DONE/ERR2 + accepted, unmapped or illegal → ERR1.
  - IDLE/DONE/ERR2 + no accepted access → IDLE.
  - ACCESS: strobe cycle; `tgtWData` = `hSWData` (data phase). If `tgtReady[idx]` = 1 → DONE, else → WAIT.
  - WAIT: `tgtReady[idx]` = 1 → DONE.
  - ERR1 → ERR2.
- On completion, register `hSRData` ← `tgtRData[idx]` for reads; writes leave `hSRData` unchanged.
- Only `tgtReady[idx]` is observed. `tgtReady` on a non-selected target is ignored.

## Timing
- Reset values: `hSReadyOut`=1, `hSResp`=00, `hSRData`=0, `tgtSel`=0, `tgtWrite`=`tgtRead`=0, `tgtAddr`=0, `tgtWData`=0, `tgtBe`=0, FSM=IDLE.
- `hSReadyOut`=0 in ACCESS, WAIT and ERR1; =1 in IDLE, DONE and ERR2.
- `hSResp`=01 in ERR1 and ERR2; 00 otherwise.
- Minimum latency: address phase at cycle 0, strobe at cycle 1 with `tgtReady` at cycle 1, `hSReadyOut`=1 with data at cycle 2. One wait state minimum.
- Back-to-back: an address phase accepted in DONE or ERR2 enters ACCESS the next cycle with no idle gap.
- Reset asserted mid-access: return to IDLE and drop all strobes and `tgtSel` on the next edge. The pending access is abandoned.

## Configuration
- `HOST_BRIDGE_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to ACCESS and increments each cycle in WAIT.
  - When the counter reaches `TIMEOUT_CYC` with no `tgtReady[idx]` → ERR1.
  - A `tgtReady` arriving after the timeout is ignored.
- Undefined: WAIT persists until `tgtReady[idx]`; no counter is instantiated.

## Structure
- Shared package `host_bridge_pkg`: FSM state enum, response constants `HRESP_OKAY`/`HRESP_ERROR`, `HTRANS_NONSEQ`/`HTRANS_SEQ`, and a byte-enable function.
- Sub-module `host_bridge_decode`: purely combinational. Outputs index, one-hot select, unmapped, illegal and byte enables. All sequencing lives in the top module.

## Test plan
- Word write to 0x0404 (`NUM_TGT`=4, window 1 at offset 0x004), `tgtReady[1]` held high → `tgtSel`=0010, `tgtBe`=1111, one `tgtWrite` pulse, `hSReadyOut` low exactly 1 cycle, `hSResp`=00.
- Byte read of 0x0C03, `tgtReady[3]` after 5 cycles with data 0xA5A5_1234 → `tgtBe`=1000, `hSRData`=0xA5A5_1234 on the ready cycle.
- Word access to 0x1000 (unmapped) or halfword at 0x0001 → two-cycle ERROR (`hSReadyOut` 0 then 1, `hSResp`=01), no strobe.
- Two back-to-back word reads to windows 0 and 2, each with immediate ready → two strobes 2 cycles apart, correct data each time.
- With `HOST_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYC`=8, target never ready → ERROR response after 8 WAIT cycles; a late `tgtReady` has no effect.
- Reset asserted in WAIT → all outputs at reset values the next cycle, FSM=IDLE.

Source files
------------

// File: rtl/host_bridge_pkg.sv
// host_bridge_pkg
// Shared definitions for the host register bridge: FSM state encoding,
// AHB response / transfer-type constants and the byte-enable helper.
// Optional feature macro used by the bridge: HOST_BRIDGE_TIMEOUT_EN.
package host_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_e;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Byte lanes touched by an access of the given AHB size at the given
  // low address bits. Sizes above word never reach a target, so they
  // simply fall into the full-word case.
  function automatic logic [3:0] byte_en(input logic [2:0] size,
                                         input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      3'd0:    be = 4'b0001 << addr_lo;
      3'd1:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/host_bridge_decode.sv
// host_bridge_decode
// Purely combinational address/size decode for the host bridge.
// Ports:
//   addr_i      AHB address
//   size_i      AHB transfer size
//   idx_o       target window index
//   sel_o       one-hot target select
//   offs_o      window-relative byte address
//   unmapped_o  address bits above the index field are non-zero
//   illegal_o   size above word, or misaligned halfword/word
//   be_o        byte enables
module host_bridge_decode
  import host_bridge_pkg::*;
#(
  parameter int NUM_TGT    = 4,
  parameter int TGT_ADDR_W = 10,
  parameter int ADDR_W     = 16,
  parameter int IDX_W      = $clog2(NUM_TGT)
) (
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [2:0]            size_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic [NUM_TGT-1:0]    sel_o,
  output logic [TGT_ADDR_W-1:0] offs_o,
  output logic                  unmapped_o,
  output logic                  illegal_o,
  output logic [3:0]            be_o
);

  localparam int HI_LSB = TGT_ADDR_W + IDX_W;

  assign idx_o  = addr_i[TGT_ADDR_W +: IDX_W];
  assign offs_o = addr_i[TGT_ADDR_W-1:0];
  assign be_o   = byte_en(size_i, addr_i[1:0]);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TGT; gi++) begin : g_sel
      assign sel_o[gi] = (idx_o == IDX_W'(gi));
    end

    // When the windows exactly fill the address space nothing is unmapped.
    if (ADDR_W > HI_LSB) begin : g_hi
      assign unmapped_o = |addr_i[ADDR_W-1:HI_LSB];
    end else begin : g_no_hi
      assign unmapped_o = 1'b0;
    end
  endgenerate

  always_comb begin
    illegal_o = 1'b0;
    if (size_i > 3'd2)
      illegal_o = 1'b1;
    else if (size_i == 3'd1 && addr_i[0])
      illegal_o = 1'b1;
    else if (size_i == 3'd2 && addr_i[1:0] != 2'b00)
      illegal_o = 1'b1;
  end

endmodule

// File: rtl/host_reg_bridge.sv
// host_reg_bridge
// AHB-Lite slave that decodes host accesses into NUM_TGT register windows,
// issues one-cycle read/write strobes to the selected target, stalls the
// bus until that target signals ready and returns its read data.
// Unmapped or illegal accesses get a two-cycle ERROR response.
// Optional: define HOST_BRIDGE_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYC cycles with an ERROR response.
// Ports:
//   macPIClk, macPIClkHardRst      clock, synchronous active-high reset
//   hSSel/hSWrite/hSReadyIn/hSTrans/hSSize/hSAddr/hSWData  AHB slave inputs
//   hSRData/hSReadyOut/hSResp      AHB slave outputs
//   tgtSel/tgtWrite/tgtRead/tgtAddr/tgtWData/tgtBe  target request
//   tgtReady/tgtRData              per-target completion and read data
module host_reg_bridge
  import host_bridge_pkg::*;
#(
  parameter int NUM_TGT     = 4,
  parameter int TGT_ADDR_W  = 10,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      macPIClk,
  input  logic                      macPIClkHardRst,
  input  logic                      hSSel,
  input  logic                      hSWrite,
  input  logic                      hSReadyIn,
  input  logic [1:0]                hSTrans,
  input  logic [2:0]                hSSize,
  input  logic [ADDR_W-1:0]         hSAddr,
  input  logic [DATA_W-1:0]         hSWData,
  output logic [DATA_W-1:0]         hSRData,
  output logic                      hSReadyOut,
  output logic [1:0]                hSResp,
  output logic [NUM_TGT-1:0]        tgtSel,
  output logic                      tgtWrite,
  output logic                      tgtRead,
  output logic [TGT_ADDR_W-1:0]     tgtAddr,
  output logic [DATA_W-1:0]         tgtWData,
  output logic [3:0]                tgtBe,
  input  logic [NUM_TGT-1:0]        tgtReady,
  input  logic [NUM_TGT*DATA_W-1:0] tgtRData
);

  localparam int IDX_W = $clog2(NUM_TGT);

  genvar gi;
  generate
    if (NUM_TGT < 2 || NUM_TGT > 8 || (1 << IDX_W) != NUM_TGT) begin : g_bad_num
      $error("host_reg_bridge: NUM_TGT must be a power of two in 2..8");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_tmo
      $error("host_reg_bridge: TIMEOUT_CYC must be in 1..65535");
    end
    if (ADDR_W < TGT_ADDR_W + IDX_W) begin : g_bad_addr
      $error("host_reg_bridge: ADDR_W too small for the window map");
    end
  endgenerate

  // Decode of the current address phase
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_TGT-1:0]    dec_sel;
  logic [TGT_ADDR_W-1:0] dec_offs;
  logic                  dec_unmapped;
  logic                  dec_illegal;
  logic [3:0]            dec_be;

  host_bridge_decode #(
    .NUM_TGT    (NUM_TGT),
    .TGT_ADDR_W (TGT_ADDR_W),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr_i     (hSAddr),
    .size_i     (hSSize),
    .idx_o      (dec_idx),
    .sel_o      (dec_sel),
    .offs_o     (dec_offs),
    .unmapped_o (dec_unmapped),
    .illegal_o  (dec_illegal),
    .be_o       (dec_be)
  );

  // Per-target read data as an array so the selected slice is a plain index
  logic [DATA_W-1:0] rdata_arr [NUM_TGT];
  generate
    for (gi = 0; gi < NUM_TGT; gi++) begin : g_rdata
      assign rdata_arr[gi] = tgtRData[gi*DATA_W +: DATA_W];
    end
  endgenerate

  bridge_state_e         state_q, state_d;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic [NUM_TGT-1:0]    sel_q;
  logic                  wr_stb_q;
  logic                  rd_stb_q;
  logic [TGT_ADDR_W-1:0] addr_q;
  logic [3:0]            be_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;

  logic accept;
  logic start;
  logic done;
  logic sel_ready;
  logic tmo_hit;
  logic ready_out;

  assign accept = hSSel && hSReadyIn &&
                  (hSTrans == HTRANS_NONSEQ || hSTrans == HTRANS_SEQ);

  // Only the latched target's ready is ever looked at.
  assign sel_ready = tgtReady[idx_q];

`ifdef HOST_BRIDGE_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Fires on the WAIT cycle in which the count would reach the limit.
  assign tmo_hit = (state_q == ST_WAIT) && ((cnt_q + 16'd1) == 16'(TIMEOUT_CYC));

  always_comb begin
    cnt_d = cnt_q;
    if (start)
      cnt_d = '0;
    else if (state_q == ST_WAIT)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge macPIClk) begin
    if (macPIClkHardRst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    done      = 1'b0;
    ready_out = 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept) begin
          if (dec_unmapped || dec_illegal) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_ACCESS;
            start   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        ready_out = 1'b0;
        if (sel_ready) begin
          state_d = ST_DONE;
          done    = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        ready_out = 1'b0;
        // A ready arriving in the same cycle as the timeout still wins.
        if (sel_ready) begin
          state_d = ST_DONE;
          done    = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: begin
        ready_out = 1'b0;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge macPIClk) begin
    if (macPIClkHardRst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      write_q  <= 1'b0;
      sel_q    <= '0;
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_stb_q <= start && hSWrite;
      rd_stb_q <= start && !hSWrite;
      if (start) begin
        idx_q   <= dec_idx;
        write_q <= hSWrite;
        sel_q   <= dec_sel;
        addr_q  <= dec_offs;
        be_q    <= dec_be;
      end else if (state_d != ST_ACCESS && state_d != ST_WAIT) begin
        sel_q <= '0;
      end
      // Write data is only valid on the bus during the strobe cycle, so
      // keep a copy for targets that complete later.
      if (state_q == ST_ACCESS)
        wdata_q <= hSWData;
      if (done && !write_q)
        rdata_q <= rdata_arr[idx_q];
    end
  end

  assign hSReadyOut = ready_out;
  assign hSResp     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign hSRData    = rdata_q;
  assign tgtSel     = sel_q;
  assign tgtWrite   = wr_stb_q;
  assign tgtRead    = rd_stb_q;
  assign tgtAddr    = addr_q;
  assign tgtBe      = be_q;
  assign tgtWData   = (state_q == ST_ACCESS) ? hSWData : wdata_q;

endmodule
